// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port, write-to-read
// bypass, optional hardwired zero register and a per-register busy scoreboard.
module regfile_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              read_busy1,
    output logic              read_busy2,
    input  logic              we,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_reg,
    output logic [ADDR_W:0]   busy_count
);

    localparam int DEPTH     = 2 ** ADDR_W;
    localparam bit ZERO_EN   = (ZERO_REG != 0);
    localparam bit BYPASS_EN = (BYPASS != 0);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic [ADDR_W:0]   count_next;
    logic              write_ok;
    logic              issue_ok;
    logic              hit1;
    logic              hit2;
    logic              zero1;
    logic              zero2;

    assign write_ok = we && !(ZERO_EN && (write_reg == '0));
    assign issue_ok = issue_valid && !(ZERO_EN && (issue_reg == '0));

    // Retire clears first so a same-register issue (the younger op) wins.
    always_comb begin
        busy_next  = busy;
        count_next = '0;
        if (we) begin
            busy_next[write_reg] = 1'b0;
        end
        if (issue_ok) begin
            busy_next[issue_reg] = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            count_next = count_next + (ADDR_W + 1)'(busy_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (write_ok) begin
                regs[write_reg] <= write_data;
            end
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

    assign hit1  = BYPASS_EN && write_ok && (write_reg == read_reg1);
    assign hit2  = BYPASS_EN && write_ok && (write_reg == read_reg2);
    assign zero1 = ZERO_EN && (read_reg1 == '0);
    assign zero2 = ZERO_EN && (read_reg2 == '0);

    always_comb begin
        read_data1 = regs[read_reg1];
        read_busy1 = busy[read_reg1];
        if (zero1) begin
            read_data1 = '0;
            read_busy1 = 1'b0;
        end else if (hit1) begin
            read_data1 = write_data;
            read_busy1 = 1'b0;
        end
    end

    always_comb begin
        read_data2 = regs[read_reg2];
        read_busy2 = busy[read_reg2];
        if (zero2) begin
            read_data2 = '0;
            read_busy2 = 1'b0;
        end else if (hit2) begin
            read_data2 = write_data;
            read_busy2 = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default build, a no-bypass build and a
// build with an ordinary register 0, all driven from the same inputs.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  read_reg1, read_reg2, write_reg, issue_reg;
    logic        we, issue_valid;
    logic [15:0] write_data;

    logic [15:0] d_rd1, d_rd2, nb_rd1, nb_rd2, nz_rd1, nz_rd2;
    logic        d_rb1, d_rb2, nb_rb1, nb_rb2, nz_rb1, nz_rb2;
    logic [4:0]  d_cnt, nb_cnt, nz_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk(clk), .rst_n(rst_n), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(d_rd1), .read_data2(d_rd2), .read_busy1(d_rb1), .read_busy2(d_rb2),
        .we(we), .write_reg(write_reg), .write_data(write_data),
        .issue_valid(issue_valid), .issue_reg(issue_reg), .busy_count(d_cnt)
    );

    regfile_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(nb_rd1), .read_data2(nb_rd2), .read_busy1(nb_rb1), .read_busy2(nb_rb2),
        .we(we), .write_reg(write_reg), .write_data(write_data),
        .issue_valid(issue_valid), .issue_reg(issue_reg), .busy_count(nb_cnt)
    );

    regfile_sb #(.ZERO_REG(0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(nz_rd1), .read_data2(nz_rd2), .read_busy1(nz_rb1), .read_busy2(nz_rb2),
        .we(we), .write_reg(write_reg), .write_data(write_data),
        .issue_valid(issue_valid), .issue_reg(issue_reg), .busy_count(nz_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we          = 1'b0;
        issue_valid = 1'b0;
    endtask

    task automatic wr(input logic [3:0] r, input logic [15:0] d);
        we         = 1'b1;
        write_reg  = r;
        write_data = d;
    endtask

    task automatic iss(input logic [3:0] r);
        issue_valid = 1'b1;
        issue_reg   = r;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        read_reg1 = 4'd0; read_reg2 = 4'd0; write_reg = 4'd0; issue_reg = 4'd0;
        write_data = 16'h0; we = 1'b0; issue_valid = 1'b0;
        #2;
        check_eq("por_count", d_cnt, 0);
        #1 rst_n = 1'b1;
        tick();

        // Reset discards a completed write and an outstanding issue.
        wr(4'd5, 16'hBEEF); iss(4'd5); read_reg1 = 4'd5;
        tick(); idle(); #1;
        check_eq("pre_rst_data", d_rd1, 16'hBEEF);
        check_eq("pre_rst_busy", d_rb1, 1);
        check_eq("pre_rst_count", d_cnt, 1);
        rst_n = 1'b0; #1;
        check_eq("rst_data", d_rd1, 16'h0000);
        check_eq("rst_busy", d_rb1, 0);
        check_eq("rst_count", d_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Write then read, with and without bypass.
        read_reg1 = 4'd3; wr(4'd3, 16'h1234); #1;
        check_eq("byp_same_cycle", d_rd1, 16'h1234);
        check_eq("nobyp_same_cycle", nb_rd1, 16'h0000);
        tick(); idle(); #1;
        check_eq("byp_next_cycle", d_rd1, 16'h1234);
        check_eq("nobyp_next_cycle", nb_rd1, 16'h1234);

        // Zero register.
        do_reset();
        read_reg1 = 4'd0; wr(4'd0, 16'hFFFF); iss(4'd0); #1;
        check_eq("zr_bypass_data", d_rd1, 16'h0000);
        check_eq("zr_bypass_busy", d_rb1, 0);
        check_eq("nz_bypass_data", nz_rd1, 16'hFFFF);
        tick(); idle(); #1;
        check_eq("zr_data", d_rd1, 16'h0000);
        check_eq("zr_busy", d_rb1, 0);
        check_eq("zr_count", d_cnt, 0);
        check_eq("nz_data", nz_rd1, 16'hFFFF);
        check_eq("nz_busy", nz_rb1, 1);
        check_eq("nz_count", nz_cnt, 1);

        // Scoreboard issue / retire.
        do_reset();
        read_reg1 = 4'd7; iss(4'd7); #1;
        check_eq("issue_same_cycle_busy", d_rb1, 0);
        tick(); idle(); #1;
        check_eq("issue_busy", d_rb1, 1);
        check_eq("issue_count", d_cnt, 1);
        wr(4'd7, 16'h00AA); #1;
        check_eq("retire_byp_busy", d_rb1, 0);
        check_eq("retire_byp_data", d_rd1, 16'h00AA);
        check_eq("retire_nobyp_busy", nb_rb1, 1);
        check_eq("retire_nobyp_data", nb_rd1, 16'h0000);
        tick(); idle(); #1;
        check_eq("retired_count", d_cnt, 0);
        check_eq("retired_busy_nb", nb_rb1, 0);
        check_eq("retired_data_nb", nb_rd1, 16'h00AA);

        // Simultaneous retire and issue.
        do_reset();
        read_reg1 = 4'd2; read_reg2 = 4'd9;
        iss(4'd2); tick(); idle(); #1;
        check_eq("r2_busy", d_rb1, 1);
        wr(4'd2, 16'h0005); iss(4'd2); tick(); idle(); #1;
        check_eq("same_reg_busy", d_rb1, 1);
        check_eq("same_reg_count", d_cnt, 1);
        wr(4'd2, 16'h0006); iss(4'd9); tick(); idle(); #1;
        check_eq("diff_reg_r2", d_rb1, 0);
        check_eq("diff_reg_r9", d_rb2, 1);
        check_eq("diff_reg_count", d_cnt, 1);
        wr(4'd4, 16'h0007); tick(); idle(); #1;
        check_eq("retire_not_busy_count", d_cnt, 1);

        // Full scoreboard.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            iss(4'(i)); tick();
        end
        idle(); #1;
        check_eq("full_count_nz", nz_cnt, 16);
        check_eq("full_count_zr", d_cnt, 15);
        iss(4'd4); tick(); idle(); #1;
        check_eq("reissue_count", nz_cnt, 16);
        for (int i = 0; i < 16; i++) begin
            wr(4'(i), 16'(i)); tick(); idle(); #1;
            check_eq($sformatf("drain_count_%0d", i), nz_cnt, 32'(15 - i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file for the pipelined CPU datapath, with two asynchronous read ports and one synchronous write port. It adds asynchronous clearing, an optional hardwired zero register, and write-to-read bypass. A per-register scoreboard tracks writes that decode has issued but writeback has not yet retired, so decode can detect RAW hazards. It sits between the decode stage (reads, issue) and the writeback stage (write, retire).

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 4, register address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, 1: register 0 always reads 0, ignores writes and never becomes busy; 0: register 0 is ordinary
- BYPASS, 1, 1: a same-cycle write is forwarded to matching reads and clears their busy flag; 0: no forwarding

- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- read_reg1  in  ADDR_W  read port 1 address
- read_reg2  in  ADDR_W  read port 2 address
- read_data1  out  DATA_W  port 1 data, combinational
- read_data2  out  DATA_W  port 2 data, combinational
- read_busy1  out  1  port 1 register has an outstanding issued write
- read_busy2  out  1  port 2 register has an outstanding issued write
- we  in  1  writeback write enable; also retires the scoreboard entry
- write_reg  in  ADDR_W  write address
- write_data  in  DATA_W  write data
- issue_valid  in  1  decode issues an instruction that will write issue_reg
- issue_reg  in  ADDR_W  destination of the issued instruction
- busy_count  out  ADDR_W+1  number of registers currently busy

## Operation
- Storage: DEPTH × DATA_W registers plus a DEPTH-bit busy vector.
- Reset (rst_n=0): all registers are 0, all busy bits are 0 and busy_count is 0, immediately and without waiting for clk.
  - Reset asserted mid-operation discards all pending writes and issues.
- Write: on posedge clk with we=1, reg[write_reg] <= write_data.
  - With ZERO_REG=1, a write to register 0 is dropped.
- Read, BYPASS=1: if we=1, write_reg==read_regN and the address is not a dropped zero-register write, read_dataN = write_data. Otherwise read_dataN = reg[read_regN].
- Read, BYPASS=0: read_dataN = reg[read_regN] always.
- Zero register: with ZERO_REG=1, read_regN==0 gives read_dataN=0 and read_busyN=0 regardless of bypass.
- Scoreboard update on posedge clk:
  - we=1 clears busy[write_reg].
  - issue_valid=1 sets busy[issue_reg]; register 0 is excluded when ZERO_REG=1.
  - Same register cleared and set in one cycle: set wins, because the new issue is younger than the retiring write.
  - Different registers: both updates apply.
  - we=1 on a register that is not busy is legal and leaves its busy bit 0.
  - Repeated issue to an already-busy register leaves it busy. There is a single bit per register, not a count, so retiring it takes one writeback.
- read_busyN:
  - Equals busy[read_regN] in general.
  - With BYPASS=1, it is forced to 0 when the same-cycle write matches read_regN, because the data is available through the bypass.
  - A same-cycle issue does not affect read_busyN until the next cycle.
- busy_count: registered popcount of the busy vector as it will be after the edge. It changes in the same cycle as the busy bits; range 0..DEPTH.

## Timing
- Read latency is 0 cycles (combinational from the address, register contents, and the bypass inputs).
- Write latency: data is visible through the array on the cycle after the we edge, and in the same cycle through the bypass.
- Scoreboard: busy is visible the cycle after issue and clears the cycle after we. With bypass it already reads not-busy in the we cycle itself.
- There are no handshakes and no stalls inside the block; decode derives its stall from read_busyN.

## Test plan
- Reset: write 0xBEEF to r5, issue r5, then pulse rst_n low between edges → read_data of r5 = 0x0000 and read_busy=0 immediately; busy_count=0.
- Write then read: we to r3 with 0x1234 → in the same cycle, with BYPASS=1, read_data1(r3)=0x1234. On the next cycle, with we=0, it still reads 0x1234. With BYPASS=0, the same-cycle read shows the old value 0x0000.
- Zero register: ZERO_REG=1; write 0xFFFF to r0 and issue r0 → read_data(r0)=0 and read_busy=0, busy_count unchanged. With ZERO_REG=0, r0 reads 0xFFFF after the write.
- Scoreboard: issue r7 → next cycle read_busy(r7)=1 and busy_count=1. Then we r7=0x00AA → in the same cycle read_busy=0 and data=0x00AA; the following cycle busy_count=0.
- Simultaneous retire/issue: r2 busy; in one cycle we r2 and issue r2 → r2 stays busy and busy_count is unchanged. The same cycle with we r2 and issue r9 → r2 clears, r9 sets, count unchanged.
- Full scoreboard: ZERO_REG=0; issue all 16 registers over 16 cycles → busy_count=16 (5'b10000). Then retire all → count decrements by 1 per cycle to 0.
